// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in
// clock cycles, strobes each completed measurement with valid, and raises a
// timeout level when no rising edge arrives for TIMEOUT cycles.
module pwm_capture #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enCapture,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_lat;
  logic             running;
  logic             meas_done;
  logic             to_hit;

  // Counter increment that sticks at all-ones instead of wrapping, so a
  // very long stall can never alias back onto the timeout threshold.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c);
    sat_inc = (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign running = (state != IDLE);

  // A measurement completes on a rise while measuring; a disable in the same
  // cycle suppresses it. The timeout fires only when no rise competes.
  assign meas_done = (state == MEASURE) & enCapture & rise;
  assign to_hit    = running & enCapture & ~rise & (cnt == TIMEOUT_C);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; disable has priority over edges and timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enCapture) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (!enCapture) state_nxt = IDLE;
        else if (rise)  state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!enCapture)  state_nxt = IDLE;
        else if (to_hit) state_nxt = WAIT_RISE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle counter: restarts at 1 on each rise, saturates otherwise, frozen in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (running) begin
      cnt <= rise ? CNT_ONE : sat_inc(cnt);
    end
  end

  // Latch the count at the falling edge; it becomes high_time at the next rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_lat <= '0;
    end else if ((state == MEASURE) && enCapture && fall) begin
      hi_lat <= cnt;
    end
  end

  // Publish measurements and maintain the timeout level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= meas_done;
      if (meas_done) begin
        period    <= cnt;
        high_time <= hi_lat;
        timeout   <= 1'b0;
      end else if (to_hit) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed clock-aligned PWM patterns; expected
// measurements are queued as stimulus is issued and a negedge monitor pops and
// compares them on every valid strobe.
module tb_pwm_capture;

  localparam int W  = 32;
  localparam int TO = 50;

  logic         clock = 1'b0;
  logic         reset;
  logic         enCapture;
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] h;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   n_pushed = 0;
  int   n_valid  = 0;
  logic valid_prev = 1'b0;

  pwm_capture #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .enCapture (enCapture),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(l);
  endtask

  task automatic push(input int p, input int h);
    expq.push_back({W'(p), W'(h)});
    n_pushed++;
  endtask

  // Monitor: every valid strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset === 1'b0 && valid === 1'b1) begin
      n_valid++;
      if (valid_prev === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL valid_width actual=2+ cycles required=1 cycle");
      end
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual period=%0d high_time=%0d required=no strobe",
                 period, high_time);
      end else begin
        mon_e = expq.pop_front();
        check("period", period, mon_e.p);
        check("high_time", high_time, mon_e.h);
        check("timeout_on_valid", 32'(timeout), 32'd0);
      end
    end
    valid_prev = (reset === 1'b0) ? valid : 1'b0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=time limit reached required=bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    enCapture = 1'b0;
    pwm_in    = 1'b0;
    tick(3);
    check("reset_period", period, 32'd0);
    check("reset_high_time", high_time, 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick(2);

    // PWM while disabled: nothing published.
    repeat (3) pulse(3, 18);
    check("disabled_period", period, 32'd0);

    // Steady 3/21: first rise is only a reference.
    enCapture = 1'b1;
    tick(2);
    pulse(3, 18);
    repeat (3) begin
      push(21, 3);
      pulse(3, 18);
    end

    // Duty change to 10/40 at a rising edge.
    push(21, 3);
    pulse(10, 30);
    repeat (2) begin
      push(40, 10);
      pulse(10, 30);
    end

    // Timeout: one more rise then hold low; fires 50 counts after that rise.
    push(40, 10);
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(42);
    check("timeout_before", 32'(timeout), 32'd0);
    tick(1);
    check("timeout_at_50", 32'(timeout), 32'd1);
    check("timeout_hold_period", period, 32'd40);
    check("timeout_hold_high", high_time, 32'd10);
    tick(20);
    check("timeout_level", 32'(timeout), 32'd1);

    // Resume: first rise discarded, second measures and clears timeout.
    pulse(3, 18);
    check("timeout_after_ref_rise", 32'(timeout), 32'd1);
    push(21, 3);
    pulse(3, 18);
    check("timeout_cleared", 32'(timeout), 32'd0);

    // Minimum period 2/2.
    push(21, 3);
    pulse(2, 2);
    repeat (4) begin
      push(4, 2);
      pulse(2, 2);
    end

    // Disable between a fall and the following rise.
    push(4, 2);
    pwm_in = 1'b1;
    tick(3);
    pwm_in = 1'b0;
    tick(8);
    enCapture = 1'b0;
    tick(10);
    pulse(3, 18);
    check("disable_hold_period", period, 32'd4);
    check("disable_hold_high", high_time, 32'd2);
    check("disable_hold_timeout", 32'(timeout), 32'd0);

    // Re-enable: one discarded edge, then correct measurements.
    enCapture = 1'b1;
    tick(1);
    pulse(5, 7);
    push(12, 5);
    pulse(5, 7);
    push(12, 5);
    pulse(5, 7);
    tick(5);
    check("queue_drained", 32'(expq.size()), 32'd0);
    check("valid_count", 32'(n_valid), 32'(n_pushed));
    check("last_period", period, 32'd12);

    // Asynchronous reset mid-cycle, between clock edges.
    pwm_in = 1'b1;
    tick(2);
    #2;
    reset = 1'b1;
    #1;
    check("async_period", period, 32'd0);
    check("async_high_time", high_time, 32'd0);
    check("async_valid", 32'(valid), 32'd0);
    check("async_timeout", 32'(timeout), 32'd0);
    pwm_in = 1'b0;
    tick(2);
    enCapture = 1'b0;
    reset     = 1'b0;
    tick(1);
    repeat (3) pulse(3, 18);
    check("post_reset_period", period, 32'd0);
    check("final_valid_count", 32'(n_valid), 32'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
